cfs_apb_master: RTL and testbench

APB initiator that turns a single-outstanding valid/ready request stream into APB setup/access transfers. It returns read data and error status on a valid/ready response channel. The block sits on the `cfs_apb_if` signal set, so register-access sequences reach APB slaves such as the aligner register file. It handles wait states, slave errors and a bounded wait timeout.

---
 rtl/cfs_apb_pkg.sv | 19 +
 rtl/cfs_apb_if.sv | 26 ++
 rtl/cfs_apb_master.sv | 126 ++++++++++++
 tb/tb_cfs_apb_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfs_apb_pkg.sv
// Shared types and limits for the cfs APB initiator and its interface.
package cfs_apb_pkg;

    localparam int unsigned CFS_APB_MAX_ADDR_WIDTH = 32;
    localparam int unsigned CFS_APB_MAX_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } cfs_apb_state_t;

    typedef enum logic {
        CFS_APB_READ  = 1'b0,
        CFS_APB_WRITE = 1'b1
    } cfs_apb_dir_t;

endpackage

// File: rtl/cfs_apb_if.sv
// APB signal bundle shared by the initiator and any APB completer.
interface cfs_apb_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/cfs_apb_master.sv
// APB initiator: one outstanding valid/ready request becomes an APB setup/access transfer,
// with wait states, slave errors and an optional access timeout reported on a response channel.
module cfs_apb_master
    import cfs_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    cfs_apb_if.master             apb
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    cfs_apb_state_t        r_state;
    logic [ADDR_WIDTH-1:0] r_paddr;
    cfs_apb_dir_t          r_dir;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_psel;
    logic                  r_penable;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic                  w_timeout_hit;

    // The counter holds the number of earlier stalled ACCESS cycles, so the threshold
    // is reached on the TIMEOUT_CYCLES-th stalled cycle itself.
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == CNT_LAST);

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_state       <= IDLE;
            r_paddr       <= '0;
            r_dir         <= CFS_APB_READ;
            r_pwdata      <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_wait_cnt    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_paddr  <= req_addr;
                        r_dir    <= cfs_apb_dir_t'(req_write);
                        r_pwdata <= req_write ? req_wdata : '0;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= ACCESS;
                end
                ACCESS: begin
                    // pready takes priority over a timeout reached in the same cycle.
                    if (apb.pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= apb.pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= (r_dir == CFS_APB_READ) ? apb.prdata : '0;
                        r_state       <= RESP;
                    end else if (w_timeout_hit) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_state       <= RESP;
                    end else if (r_wait_cnt != CNT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = preset_n && (r_state == IDLE);

    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

    assign apb.paddr   = r_paddr;
    assign apb.pwrite  = (r_dir == CFS_APB_WRITE);
    assign apb.psel    = r_psel;
    assign apb.penable = r_penable;
    assign apb.pwdata  = r_pwdata;

endmodule

// File: tb/tb_cfs_apb_master.sv
// Bench for cfs_apb_master: directed vector table, reset corners and random transfers
// checked against a transaction-level expectation of each response.
module tb_cfs_apb_master;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    cfs_apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_if ();

    cfs_apb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .apb        (apb_if.master)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;        // pready=0 ACCESS cycles before the slave answers
        logic          err;          // pslverr driven together with pready
        logic [DW-1:0] rdata;
        int            bp;           // cycles of rsp_ready=0 before the handshake
        logic          err_in_wait;  // pslverr driven during stalled cycles
        logic          pend;         // next request held valid through the response stall
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    string tag = "";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL [%s] %s: got 0x%08h, expected 0x%08h", tag, name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Starts in a cycle where the DUT is idle; returns in the cycle after the rsp handshake.
    task automatic run_xfer(input vec_t v);
        logic          tmo;
        int            acc;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] exp_wd;
        logic          exp_err;
        tmo     = (TO != 0) && (v.waits >= int'(TO));
        acc     = tmo ? int'(TO) : v.waits + 1;
        exp_rd  = (tmo || v.wr) ? '0 : v.rdata;
        exp_wd  = v.wr ? v.wdata : '0;
        exp_err = tmo | v.err;

        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = $urandom;

        chk("setup_psel", 32'(apb_if.psel), 32'd1);
        chk("setup_penable", 32'(apb_if.penable), 32'd0);
        chk("setup_paddr", 32'(apb_if.paddr), 32'(v.addr));
        chk("setup_pwrite", 32'(apb_if.pwrite), 32'(v.wr));
        chk("setup_pwdata", apb_if.pwdata, exp_wd);
        chk("setup_req_ready", 32'(req_ready), 32'd0);
        tick();

        for (int i = 0; i < acc; i++) begin
            chk("acc_psel", 32'(apb_if.psel), 32'd1);
            chk("acc_penable", 32'(apb_if.penable), 32'd1);
            chk("acc_paddr", 32'(apb_if.paddr), 32'(v.addr));
            chk("acc_pwrite", 32'(apb_if.pwrite), 32'(v.wr));
            chk("acc_pwdata", apb_if.pwdata, exp_wd);
            chk("acc_rsp_valid", 32'(rsp_valid), 32'd0);
            if (i == v.waits) begin
                apb_if.pready  = 1'b1;
                apb_if.pslverr = v.err;
                apb_if.prdata  = v.rdata;
            end else begin
                apb_if.pready  = 1'b0;
                apb_if.pslverr = v.err_in_wait;
                apb_if.prdata  = $urandom;
            end
            tick();
        end
        apb_if.pready  = 1'b0;
        apb_if.pslverr = 1'b0;

        if (v.pend) begin
            req_valid = 1'b1;
            req_write = 1'($urandom);
            req_addr  = AW'($urandom);
        end
        for (int j = 0; j <= v.bp; j++) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(tmo));
            chk("rsp_psel", 32'(apb_if.psel), 32'd0);
            chk("rsp_penable", 32'(apb_if.penable), 32'd0);
            chk("rsp_req_ready", 32'(req_ready), 32'd0);
            chk("rsp_paddr_kept", 32'(apb_if.paddr), 32'(v.addr));
            rsp_ready = (j == v.bp);
            tick();
        end
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    vec_t vecs[9];

    initial begin
        apb_if.pready  = 1'b0;
        apb_if.prdata  = '0;
        apb_if.pslverr = 1'b0;

        vecs[0] = '{1'b1, 16'h0008, 32'hDEADBEEF, 0, 1'b0, 32'hA5A5A5A5, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h000C, 32'h0, 2, 1'b0, 32'h12345678, 0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h0010, 32'h0, 0, 1'b1, 32'h0BADF00D, 1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h0014, 32'h0, 2, 1'b0, 32'h55AA55AA, 0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'h0018, 32'h0, 4, 1'b0, 32'hCAFEF00D, 0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h001C, 32'h0, 3, 1'b0, 32'h87654321, 0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h0004, 32'h01020304, 10, 1'b1, 32'hFFFFFFFF, 2, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h0024, 32'h0, 1, 1'b0, 32'h13579BDF, 5, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 16'h0028, 32'hFEEDFACE, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0};

        // Reset with a request already presented: nothing may be accepted.
        tag = "reset";
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'hFFFF;
        req_wdata = 32'hFFFFFFFF;
        tick();
        tick();
        chk("req_ready", 32'(req_ready), 32'd0);
        chk("psel", 32'(apb_if.psel), 32'd0);
        chk("penable", 32'(apb_if.penable), 32'd0);
        chk("paddr", 32'(apb_if.paddr), 32'd0);
        chk("pwrite", 32'(apb_if.pwrite), 32'd0);
        chk("pwdata", apb_if.pwdata, 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rsp_rdata", rsp_rdata, 32'd0);
        chk("rsp_err", 32'(rsp_err), 32'd0);
        chk("rsp_timeout", 32'(rsp_timeout), 32'd0);
        req_valid = 1'b0;
        preset_n  = 1'b1;
        tick();
        chk("req_ready_after", 32'(req_ready), 32'd1);

        for (int k = 0; k < 9; k++) begin
            tag = $sformatf("vec%0d", k);
            run_xfer(vecs[k]);
            if (!vecs[k].pend) tick();
        end

        // Reset during wait states drops the transfer without a response.
        tag = "reset_mid_access";
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0020;
        tick();
        req_valid = 1'b0;
        apb_if.pready = 1'b0;
        tick();
        tick();
        chk("psel_before", 32'(apb_if.psel), 32'd1);
        preset_n = 1'b0;
        tick();
        preset_n = 1'b1;
        chk("psel", 32'(apb_if.psel), 32'd0);
        chk("penable", 32'(apb_if.penable), 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'd0);
        chk("paddr", 32'(apb_if.paddr), 32'd0);
        apb_if.pready = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_rsp", 32'(rsp_valid), 32'd0);
            chk("no_psel", 32'(apb_if.psel), 32'd0);
        end
        apb_if.pready = 1'b0;
        rsp_ready = 1'b0;
        tag = "after_reset";
        run_xfer('{1'b0, 16'h0030, 32'h0, 1, 1'b0, 32'h2468ACE0, 0, 1'b0, 1'b0});
        tick();

        // Random transfers; waits range past TO so timeouts and near-misses both appear.
        for (int k = 0; k < 40; k++) begin
            vec_t v;
            v.wr          = 1'($urandom);
            v.addr        = AW'($urandom);
            v.wdata       = $urandom;
            v.waits       = int'($urandom_range(0, 6));
            v.err         = 1'($urandom);
            v.rdata       = $urandom;
            v.bp          = int'($urandom_range(0, 3));
            v.err_in_wait = 1'($urandom);
            v.pend        = (k != 39) && ($urandom_range(0, 3) == 0);
            tag = $sformatf("rand%0d", k);
            run_xfer(v);
            if (!v.pend) begin
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
            end
        end
        req_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
